// File: rtl/infrared_rcv_pkg.sv
// Shared types, nominal NEC timings and cycle-conversion helpers for the IR receiver.
// Timing constants are kept in microseconds so any clock frequency can derive its own windows.
package infrared_rcv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LOW,
    LEAD_SPACE,
    BIT_LOW,
    BIT_SPACE
  } state_t;

  localparam int CNT_W = 20;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  // Nominal NEC interval widths in microseconds.
  localparam longint US_LEAD_LO   = 9000;
  localparam longint US_FRAME_SP  = 4500;
  localparam longint US_REPEAT_SP = 2250;
  localparam longint US_BIT_LO    = 560;
  localparam longint US_ZERO_SP   = 560;
  localparam longint US_ONE_SP    = 1690;
  localparam longint US_TIMEOUT   = 10000;

  // Cycles for a width scaled by pct percent (100 = nominal, 90 = lower bound, ...).
  function automatic cnt_t cycles(input longint freq_hz, input longint us, input longint pct);
    return cnt_t'((freq_hz * us * pct) / 64'sd100_000_000);
  endfunction

  function automatic logic in_win(input cnt_t w, input cnt_t lo, input cnt_t hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/infrared_rcv_edge_sync.sv
// Two-flop synchronizer for the IR pin plus a history flop giving single-cycle edge strobes.
// Flops reset to 1 (idle line) so leaving reset never produces a spurious fall.
module ir_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic cur_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b1;
      cur_reg  <= 1'b1;
      prev_reg <= 1'b1;
    end else begin
      meta_reg <= din;
      cur_reg  <= meta_reg;
      prev_reg <= cur_reg;
    end
  end

  assign fall = prev_reg & ~cur_reg;
  assign rise = ~prev_reg & cur_reg;

endmodule

// File: rtl/infrared_rcv.sv
// NEC infrared decoder: measures burst/space widths and assembles 32-bit frames into
// {4'h0, addr, cmd}; a repeat code after a good frame yields a one-cycle repeat_en pulse.
module infrared_rcv #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TOL_PCT     = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        infrared_in,
  output logic [19:0] data,
  output logic        repeat_en
);
  import infrared_rcv_pkg::*;

  localparam longint F_HZ = longint'(CLK_FREQ_HZ);
  localparam longint P_LO = longint'(100 - TOL_PCT);
  localparam longint P_HI = longint'(100 + TOL_PCT);

  localparam cnt_t LEAD_LO_MIN   = cycles(F_HZ, US_LEAD_LO, P_LO);
  localparam cnt_t LEAD_LO_MAX   = cycles(F_HZ, US_LEAD_LO, P_HI);
  localparam cnt_t FRAME_SP_MIN  = cycles(F_HZ, US_FRAME_SP, P_LO);
  localparam cnt_t FRAME_SP_MAX  = cycles(F_HZ, US_FRAME_SP, P_HI);
  localparam cnt_t REPEAT_SP_MIN = cycles(F_HZ, US_REPEAT_SP, P_LO);
  localparam cnt_t REPEAT_SP_MAX = cycles(F_HZ, US_REPEAT_SP, P_HI);
  localparam cnt_t BIT_LO_MIN    = cycles(F_HZ, US_BIT_LO, P_LO);
  localparam cnt_t BIT_LO_MAX    = cycles(F_HZ, US_BIT_LO, P_HI);
  localparam cnt_t ZERO_SP_MIN   = cycles(F_HZ, US_ZERO_SP, P_LO);
  localparam cnt_t ZERO_SP_MAX   = cycles(F_HZ, US_ZERO_SP, P_HI);
  localparam cnt_t ONE_SP_MIN    = cycles(F_HZ, US_ONE_SP, P_LO);
  localparam cnt_t ONE_SP_MAX    = cycles(F_HZ, US_ONE_SP, P_HI);
  localparam cnt_t TIMEOUT       = cycles(F_HZ, US_TIMEOUT, 64'sd100);

  logic rise;
  logic fall;

  ir_edge_sync u_edge_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .din   (infrared_in),
    .rise  (rise),
    .fall  (fall)
  );

  state_t      state_reg, state_next;
  cnt_t        cnt_reg;
  logic [4:0]  bit_idx_reg, bit_idx_next;
  logic [31:0] shift_reg, shift_next;
  logic [19:0] data_reg, data_next;
  logic        have_frame_reg, have_frame_next;
  logic        repeat_reg, repeat_next;

  logic        is_zero;
  logic        is_one;
  logic [31:0] shifted;

  // Width of the interval that just ended is the count held when the edge arrives.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_reg <= '0;
    end else if (rise || fall) begin
      cnt_reg <= '0;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_reg <= cnt_reg + cnt_t'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg      <= IDLE;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      data_reg       <= '0;
      have_frame_reg <= 1'b0;
      repeat_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      data_reg       <= data_next;
      have_frame_reg <= have_frame_next;
      repeat_reg     <= repeat_next;
    end
  end

  assign is_zero = in_win(cnt_reg, ZERO_SP_MIN, ZERO_SP_MAX);
  assign is_one  = in_win(cnt_reg, ONE_SP_MIN, ONE_SP_MAX);
  // LSB-first arrival: after 32 shifts the first bit sits at bit 0 (addr byte lowest).
  assign shifted = {is_one, shift_reg[31:1]};

  always_comb begin
    state_next      = state_reg;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    data_next       = data_reg;
    have_frame_next = have_frame_reg;
    repeat_next     = 1'b0;

    // A stalled line takes priority over any edge seen in the same cycle.
    if (state_reg != IDLE && cnt_reg > TIMEOUT) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (fall) state_next = LEAD_LOW;
        end
        LEAD_LOW: begin
          if (rise) state_next = in_win(cnt_reg, LEAD_LO_MIN, LEAD_LO_MAX) ? LEAD_SPACE : IDLE;
        end
        LEAD_SPACE: begin
          if (fall) begin
            state_next = IDLE;
            if (in_win(cnt_reg, FRAME_SP_MIN, FRAME_SP_MAX)) begin
              state_next   = BIT_LOW;
              bit_idx_next = '0;
              shift_next   = '0;
            end else if (in_win(cnt_reg, REPEAT_SP_MIN, REPEAT_SP_MAX) && have_frame_reg) begin
              repeat_next = 1'b1;
            end
          end
        end
        BIT_LOW: begin
          if (rise) state_next = in_win(cnt_reg, BIT_LO_MIN, BIT_LO_MAX) ? BIT_SPACE : IDLE;
        end
        BIT_SPACE: begin
          if (fall) begin
            if (is_zero || is_one) begin
              shift_next = shifted;
              if (bit_idx_reg == 5'd31) begin
                state_next = IDLE;
                if (shifted[7:0] == ~shifted[15:8] && shifted[23:16] == ~shifted[31:24]) begin
                  data_next       = {4'h0, shifted[7:0], shifted[23:16]};
                  have_frame_next = 1'b1;
                end
              end else begin
                bit_idx_next = bit_idx_reg + 5'd1;
                state_next   = BIT_LOW;
              end
            end else begin
              state_next = IDLE;
              shift_next = '0;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign data      = data_reg;
  assign repeat_en = repeat_reg;

endmodule

// File: tb/tb_infrared_rcv.sv
// Scoreboard bench for infrared_rcv run at a 50 kHz "system clock" so NEC frames stay short
// (one cycle = 20 us): lead 450, frame space 225, repeat space 112, burst/zero 28, one 84 cycles.
`timescale 1ns/1ps
module tb_infrared_rcv;

  localparam int T_LEAD   = 450;
  localparam int T_BADLD  = 350;  // 7 ms
  localparam int T_FSP    = 225;
  localparam int T_RSP    = 112;
  localparam int T_BIT    = 28;
  localparam int T_ZERO   = 28;
  localparam int T_ONE    = 84;
  localparam int T_BADSP  = 60;   // 1.2 ms
  localparam int T_GAP    = 600;  // longer than the 10 ms timeout

  typedef struct packed {
    logic        is_rep;
    logic [19:0] data;
  } ev_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        infrared_in = 1'b1;
  logic [19:0] data;
  logic        repeat_en;

  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t o, e;
  int  n_cmp = 0;
  int  n_fail = 0;
  int  rep_len = 0;
  logic        rep_prev = 1'b0;
  logic [19:0] data_prev = '0;

  infrared_rcv #(.CLK_FREQ_HZ(50_000), .TOL_PCT(10)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .infrared_in (infrared_in),
    .data        (data),
    .repeat_en   (repeat_en)
  );

  always #5 sys_clk = ~sys_clk;

  // Monitor: turn DUT output activity into observed events.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      data_prev = data;
      rep_len   = 0;
    end else begin
      if (repeat_en) begin
        if (!rep_prev) begin
          rep_len = 0;
          obs_q.push_back({1'b1, data});
        end
        rep_len++;
      end
      if (data !== data_prev) begin
        obs_q.push_back({1'b0, data});
        data_prev = data;
      end
    end
    rep_prev = repeat_en;
  end

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input logic lvl, input int n);
    infrared_in = lvl;
    repeat (n) @(negedge sys_clk);
  endtask

  // Drives one frame; bad_bit gets an illegal space, abort_bit stops mid-burst of that bit.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] ai, input logic [7:0] c,
                            input logic [7:0] ci, input int lead, input int bad_bit,
                            input int abort_bit);
    logic [31:0] w;
    w = {ci, c, ai, a};
    pulse(1'b0, lead);
    pulse(1'b1, T_FSP);
    for (int i = 0; i < 32; i++) begin
      if (i == abort_bit) begin
        pulse(1'b0, 10);
        return;
      end
      pulse(1'b0, T_BIT);
      pulse(1'b1, (i == bad_bit) ? T_BADSP : (w[i] ? T_ONE : T_ZERO));
    end
    pulse(1'b0, T_BIT);
    pulse(1'b1, T_GAP);
  endtask

  task automatic send_repeat();
    pulse(1'b0, T_LEAD);
    pulse(1'b1, T_RSP);
    pulse(1'b0, T_BIT);
    pulse(1'b1, T_GAP);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (5) @(negedge sys_clk);
    n_cmp++;
    if (data !== 20'h0) begin
      n_fail++; $display("FAIL reset_data: got %h required %h", data, 20'h0);
    end
    n_cmp++;
    if (repeat_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_repeat: got %b required 0", repeat_en);
    end
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    $display("reset: data=%h repeat_en=%b", data, repeat_en);
  endtask

  task automatic test_repeat_no_frame();
    send_repeat();
    n_cmp++;
    if (obs_q.size() !== 0) begin
      n_fail++; $display("FAIL repeat_no_frame_events: got %0d events required 0", obs_q.size());
    end
    n_cmp++;
    if (data !== 20'h0) begin
      n_fail++; $display("FAIL repeat_no_frame_data: got %h required 00000", data);
    end
    obs_q.delete();
    $display("repeat without frame: data=%h", data);
  endtask

  task automatic test_valid_frame(input logic [7:0] a, input logic [7:0] c, input string tag);
    exp_q.push_back({1'b0, 4'h0, a, c});
    send_frame(a, ~a, c, ~c, T_LEAD, -1, -1);
    n_cmp++;
    if (obs_q.size() !== 1) begin
      n_fail++; $display("FAIL %s_events: got %0d events required 1", tag, obs_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++; $display("FAIL %s_data: got rep=%b data=%h required rep=%b data=%h",
                           tag, o.is_rep, o.data, e.is_rep, e.data);
      end
    end
    obs_q.delete(); exp_q.delete();
    $display("%s: addr=%h cmd=%h data=%h", tag, a, c, data);
  endtask

  task automatic test_repeat(input logic [19:0] held);
    exp_q.push_back({1'b1, held});
    send_repeat();
    n_cmp++;
    if (obs_q.size() !== 1) begin
      n_fail++; $display("FAIL repeat_events: got %0d events required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++; $display("FAIL repeat_event: got rep=%b data=%h required rep=%b data=%h",
                           o.is_rep, o.data, e.is_rep, e.data);
      end
    end
    n_cmp++;
    if (rep_len !== 1) begin
      n_fail++; $display("FAIL repeat_width: got %0d cycles required 1", rep_len);
    end
    obs_q.delete(); exp_q.delete();
    $display("repeat: repeat_en width=%0d data=%h", rep_len, data);
  endtask

  // Any malformed frame: no output activity, data held.
  task automatic test_bad_frame(input logic [7:0] ci, input int lead, input int bad_bit,
                                input logic [19:0] held, input string tag);
    send_frame(8'h01, 8'hFE, 8'h12, ci, lead, bad_bit, -1);
    n_cmp++;
    if (obs_q.size() !== 0) begin
      n_fail++; $display("FAIL %s_events: got %0d events required 0", tag, obs_q.size());
    end
    n_cmp++;
    if (data !== held) begin
      n_fail++; $display("FAIL %s_data: got %h required %h", tag, data, held);
    end
    obs_q.delete();
    $display("%s: discarded, data=%h", tag, data);
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h5A, 8'hA5, 8'h33, 8'hCC, T_LEAD, -1, 15);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if (data !== 20'h0 || repeat_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got data=%h rep=%b required 00000/0", data, repeat_en);
    end
    infrared_in = 1'b1;
    sys_rst_n = 1'b1;
    repeat (T_GAP) @(negedge sys_clk);
    obs_q.delete();
    n_cmp++;
    if (data !== 20'h0) begin
      n_fail++; $display("FAIL reset_mid_after: got %h required 00000", data);
    end
    $display("reset mid-frame: data=%h", data);
  endtask

  task automatic test_back_to_back();
    test_repeat(20'h0FF0F);
    test_repeat(20'h0FF0F);
  endtask

  initial begin
    test_reset();
    test_repeat_no_frame();
    test_valid_frame(8'h4D, 8'h80, "valid_frame");
    test_repeat(20'h04D80);
    test_bad_frame(8'h00, T_LEAD, -1, 20'h04D80, "corrupt_inverse");
    test_valid_frame(8'h01, 8'h22, "after_corrupt");
    test_bad_frame(8'hED, T_BADLD, -1, 20'h00122, "short_lead");
    test_valid_frame(8'h3C, 8'h5A, "after_short_lead");
    test_bad_frame(8'hED, T_LEAD, 9, 20'h03C5A, "bad_space");
    test_valid_frame(8'hA5, 8'hC3, "after_bad_space");
    test_reset_mid_frame();
    test_valid_frame(8'hFF, 8'h0F, "after_reset");
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/infrared_rcv.md
Name: infrared_rcv

Overview:
- NEC-protocol infrared remote decoder.
- Samples the demodulated IR receiver output (idle high, active-low bursts) on a 50 MHz system clock and measures pulse and space widths.
- Decodes 32-bit frames (addr, ~addr, cmd, ~cmd) and presents addr and cmd on a 20-bit data word for display/control logic.
- Flags NEC repeat codes on repeat_en.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency. All timing constants below are derived from it in cycles; the values shown are for 50 MHz.
- TOL_PCT, 10, nominal-width tolerance window in percent, applied to every measured interval.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- infrared_in  in  1  demodulated IR input; 1 = idle/space, 0 = burst.
- data  out  20  decoded word {4'h0, addr[7:0], cmd[7:0]}.
- repeat_en  out  1  one-cycle pulse on a valid NEC repeat code.

Behaviour:
- One clock; reset is asynchronous and active-low (sys_clk, sys_rst_n).
- Reset values: data = 20'h0, repeat_en = 0, FSM = IDLE, counter = 0, shift register = 0, have_frame = 0.
- Input conditioning:
  - infrared_in passes through a 2-flop synchronizer plus one history flop.
  - fall = prev & ~cur; rise = ~prev & cur.
- Width counter (20 bits):
  - Clears on every fall/rise; otherwise increments, saturating at 2^20-1.
  - The width of the interval just ended is the counter value at the edge.
- Nominal widths at 50 MHz, each accepted within ±TOL_PCT:
  - lead low 9 ms = 450000
  - frame space 4.5 ms = 225000
  - repeat space 2.25 ms = 112500
  - bit burst 560 us = 28000
  - "0" space 560 us = 28000
  - "1" space 1690 us = 84500
- States: IDLE, LEAD_LOW, LEAD_SPACE, BIT_LOW, BIT_SPACE.
- IDLE: on fall -> LEAD_LOW.
- LEAD_LOW: on rise, lead-low width valid -> LEAD_SPACE; else -> IDLE.
- LEAD_SPACE: on fall:
  - Frame space valid -> BIT_LOW, bit index = 0.
  - Repeat space valid and have_frame = 1 -> pulse repeat_en for 1 cycle, -> IDLE.
  - Otherwise -> IDLE.
- BIT_LOW: on rise, bit-burst width valid -> BIT_SPACE; else -> IDLE.
- BIT_SPACE: on fall, classify the space:
  - "0" window -> shift in 0; "1" window -> shift in 1.
  - Neither -> IDLE and discard the partial frame.
  - Bits are LSB-first per byte; byte order is addr, ~addr, cmd, ~cmd in a 32-bit register.
  - After bit 31 is classified (on the stop-burst falling edge):
    - If addr == ~addr_inv and cmd == ~cmd_inv: data <= {4'h0, addr, cmd} on the next clock and have_frame <= 1.
    - If the checks fail: data is held.
    - -> IDLE in both cases.
  - Otherwise bit index++ and -> BIT_LOW.
- Timeout: in any non-IDLE state, counter > 10 ms (500000) with no edge -> IDLE.
- data changes only on a valid full frame; repeat frames never modify data.
- Latency: data updates ≤4 sys_clk after the stop-burst falling edge at the pin (2 sync + 1 edge + 1 register).
- Reset mid-frame: immediate return to reset values; have_frame is cleared.
- A fall arriving in the same cycle as a timeout: the timeout wins.

Decomposition:
- Shared package holds:
  - state enum
  - derived cycle constants: LEAD_LO, FRAME_SP, REPEAT_SP, BIT_LO, ZERO_SP, ONE_SP, TIMEOUT, with min/max bounds
  - counter width
- One natural sub-module: ir_edge_sync (2-flop synchronizer plus rise/fall detector).

Test Plan:
- Valid frame: addr 0x4D, cmd 0x80, with inverses, NEC timing -> data = 20'h04D80; repeat_en stays 0.
- Repeat code after a valid frame: 9 ms low, 2.25 ms high, 560 us burst -> repeat_en high for exactly 1 cycle; data remains 20'h04D80.
- Repeat code straight after reset (no prior frame) -> repeat_en stays 0; data = 0.
- Corrupted inverse: cmd 0x12 sent with cmd_inv 0x00 -> data unchanged from its previous value; FSM returns to IDLE and the next valid frame (0x01/0x22) gives data = 20'h00122.
- Out-of-tolerance lead (7 ms low) or a 1.2 ms data space -> frame discarded, data unchanged; a following good frame still decodes.
- Reset asserted midway through bit 15, then a full valid frame 0xFF/0x0F -> outputs 0 during reset, then data = 20'h0FF0F.
